// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit feeding the HI/LO registers.
// Optional macro DIV_ZERO_EXC_EN: divide by zero finishes in one cycle with a div_zero pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic               op_div, a_neg, b_neg, b_zero;
  logic [2*WIDTH:0]   acc, acc_nxt;
  logic [WIDTH-1:0]   dvsr;
  logic [CW-1:0]      cnt;
  logic               accept, start_mult, start_div, zero_start;
  logic [WIDTH:0]     hi_ext, m_ext, sum, trial;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;

  assign accept     = (state == IDLE) || (state == DONE);
  assign start_mult = accept && mult_start;
  assign start_div  = accept && !mult_start && div_start;
`ifdef DIV_ZERO_EXC_EN
  assign zero_start = start_div && (b_in == '0);
`else
  assign zero_start = 1'b0;
`endif

  assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;
  assign quo   = acc[WIDTH:1];
  assign rem   = acc[2*WIDTH:WIDTH+1];

  assign busy = (state == ITER) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (zero_start)                    state_nxt = DONE;
        else if (start_mult || start_div)  state_nxt = ITER;
        else                               state_nxt = IDLE;
      end
      ITER:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step. Mult: acc = {A, Q, q_-1}; the add is done one bit wider so
  // that subtracting the most negative multiplicand cannot overflow before the shift.
  // Div: acc = {R, Q, unused}; trial subtract of the shifted-in partial remainder.
  always_comb begin
    hi_ext  = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    m_ext   = {dvsr[WIDTH-1], dvsr};
    sum     = hi_ext;
    trial   = {acc[2*WIDTH:WIDTH+1], acc[WIDTH]} - {1'b0, dvsr};
    acc_nxt = acc;
    if (!op_div) begin
      case (acc[1:0])
        2'b01:   sum = hi_ext + m_ext;
        2'b10:   sum = hi_ext - m_ext;
        default: sum = hi_ext;
      endcase
      acc_nxt = {sum, acc[WIDTH:1]};
    end else if (!trial[WIDTH]) begin
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-1:1], 1'b1, 1'b0};
    end else begin
      acc_nxt = {acc[2*WIDTH-1:WIDTH+1], acc[WIDTH], acc[WIDTH-1:1], 1'b0, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      op_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_mult) begin
            acc    <= {{WIDTH{1'b0}}, b_in, 1'b0};
            dvsr   <= a_in;
            op_div <= 1'b0;
            cnt    <= '0;
          end else if (start_div && !zero_start) begin
            acc    <= {{WIDTH{1'b0}}, a_mag, 1'b0};
            dvsr   <= b_mag;
            op_div <= 1'b1;
            a_neg  <= a_in[WIDTH-1];
            b_neg  <= b_in[WIDTH-1];
            b_zero <= (b_in == '0);
            cnt    <= '0;
          end
        end
        ITER: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!op_div) begin
            hi_out <= acc[2*WIDTH:WIDTH+1];
            lo_out <= acc[WIDTH:1];
          end else begin
            // A zero divisor leaves quotient all ones and remainder equal to the dividend.
            lo_out <= ((a_neg ^ b_neg) && !b_zero) ? -quo : quo;
            hi_out <= a_neg ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_EXC_EN
  always_ff @(posedge clk) begin
    if (reset) div_zero <= 1'b0;
    else       div_zero <= zero_start;
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: products, signed quotients, divide by zero, abort and back-to-back.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, mult_start, div_start;
  logic [31:0] a_in, b_in;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Issues one start and waits for done; edges = posedges from the start edge to the first edge seeing done.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic busy_k0, output logic dz_at_done);
    @(negedge clk);
    mult_start = m; div_start = d; a_in = a; b_in = b;
    @(posedge clk); #1;
    mult_start = 1'b0; div_start = 1'b0;
    a_in = 32'hDEADBEEF; b_in = 32'h12345678;
    busy_k0 = busy; edges = -1; dz_at_done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        edges = k + 1;
        dz_at_done = div_zero;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_out); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int e; logic bk, dz;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, e, bk, dz);
    checks++; if (e !== 34) begin failures++; $display("FAIL mult_latency got=%0d exp=34", e); end
    checks++; if (bk !== 1'b1) begin failures++; $display("FAIL mult_busy_iter got=%b exp=1", bk); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_done got=%b exp=0", busy); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_7x-3_hi got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_7x-3_lo got=%h exp=ffffffeb", lo_out); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    run_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, e, bk, dz);
    checks++; if (hi_out !== 32'h3FFFFFFF) begin failures++; $display("FAIL mult_max_hi got=%h exp=3fffffff", hi_out); end
    checks++; if (lo_out !== 32'h00000001) begin failures++; $display("FAIL mult_max_lo got=%h exp=00000001", lo_out); end
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, e, bk, dz);
    checks++; if (hi_out !== 32'h40000000) begin failures++; $display("FAIL mult_min_hi got=%h exp=40000000", hi_out); end
    checks++; if (lo_out !== 32'h00000000) begin failures++; $display("FAIL mult_min_lo got=%h exp=00000000", lo_out); end
  endtask

  task automatic test_div();
    int e; logic bk, dz;
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, e, bk, dz);
    checks++; if (e !== 34) begin failures++; $display("FAIL div_latency got=%0d exp=34", e); end
    checks++; if (lo_out !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_-7/2_lo got=%h exp=fffffffd", lo_out); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_-7/2_hi got=%h exp=ffffffff", hi_out); end
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, e, bk, dz);
    checks++; if (lo_out !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_7/-2_lo got=%h exp=fffffffd", lo_out); end
    checks++; if (hi_out !== 32'h00000001) begin failures++; $display("FAIL div_7/-2_hi got=%h exp=00000001", hi_out); end
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, e, bk, dz);
    checks++; if (lo_out !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo_out); end
    checks++; if (hi_out !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi_out); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_ovf_div_zero got=%b exp=0", dz); end
  endtask

  task automatic test_back_to_back();
    int e; logic bk, dz;
    run_op(1'b0, 1'b1, 32'd100, 32'd7, e, bk, dz);
    checks++; if (lo_out !== 32'd14) begin failures++; $display("FAIL b2b_div_lo got=%h exp=0000000e", lo_out); end
    checks++; if (hi_out !== 32'd2) begin failures++; $display("FAIL b2b_div_hi got=%h exp=00000002", hi_out); end
    run_op(1'b1, 1'b0, 32'd5, 32'd6, e, bk, dz);
    checks++; if (bk !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bk); end
    checks++; if (e !== 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", e); end
    checks++; if (lo_out !== 32'd30) begin failures++; $display("FAIL b2b_mult_lo got=%h exp=0000001e", lo_out); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL b2b_mult_hi got=%h exp=00000000", hi_out); end
  endtask

  task automatic test_div_zero();
    int e; logic bk, dz;
    run_op(1'b0, 1'b1, 32'd5, 32'd0, e, bk, dz);
`ifdef DIV_ZERO_EXC_EN
    checks++; if (e !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", e); end
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", dz); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL dz_hi_hold got=%h exp=00000000", hi_out); end
    checks++; if (lo_out !== 32'd30) begin failures++; $display("FAIL dz_lo_hold got=%h exp=0000001e", lo_out); end
`else
    checks++; if (e !== 34) begin failures++; $display("FAIL dz_latency got=%0d exp=34", e); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL dz_flag got=%b exp=0", dz); end
    checks++; if (hi_out !== 32'd5) begin failures++; $display("FAIL dz_hi got=%h exp=00000005", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_lo got=%h exp=ffffffff", lo_out); end
`endif
  endtask

  task automatic test_abort();
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    mult_start = 1'b1; a_in = 32'd3; b_in = 32'd4;
    @(posedge clk); #1;
    mult_start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      saw_done |= done;
      if (k == 10) begin mult_start = 1'b1; div_start = 1'b1; a_in = 32'd9; b_in = 32'd9; end
      if (k == 11) begin mult_start = 1'b0; div_start = 1'b0; end
      if (k == 15) reset = 1'b1;
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL abort_hi got=%h exp=00000000", hi_out); end
    checks++; if (lo_out !== 32'd0) begin failures++; $display("FAIL abort_lo got=%h exp=00000000", lo_out); end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
  endtask

  task automatic test_both_starts();
    int e; logic bk, dz;
    run_op(1'b1, 1'b1, 32'd6, 32'hFFFFFFFE, e, bk, dz);
    checks++; if (e !== 34) begin failures++; $display("FAIL both_latency got=%0d exp=34", e); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL both_hi got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFF4) begin failures++; $display("FAIL both_lo got=%h exp=fffffff4", lo_out); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_div_zero();
    test_abort();
    test_both_starts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
